// File: rtl/zbt_req_arbiter_pkg.sv
// Shared constants and tag type for the ZBT request arbiter.
// DATA_BITS normally comes from defines.v; the fallback keeps this slice self-contained.
`ifndef DATA_BITS
`define DATA_BITS 36
`endif

package zbt_req_arbiter_pkg;

  localparam int   ZBT_ADDR_BITS    = 19;
  localparam int   ZBT_READ_LATENCY = 5;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef struct packed {
    logic vld;
    logic port;
  } rd_tag_t;

endpackage

// File: rtl/zbt_req_arbiter_read_tag_pipe.sv
// Fixed-depth delay line of {valid, port} tags that follows reads through the SRAM pipeline.
module zbt_read_tag_pipe
  import zbt_req_arbiter_pkg::*;
#(
  parameter int DEPTH = ZBT_READ_LATENCY + 1
) (
  input  logic    fpga_clk,
  input  logic    reset,
  input  rd_tag_t i_tag,
  output rd_tag_t o_tag
);

  rd_tag_t r_stage [DEPTH];

  always_ff @(posedge fpga_clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/zbt_req_arbiter.sv
// Two-port round-robin arbiter merging A/B commands onto the ZBT controller user port.
// Define ZBT_ARB_BURST_EN to let the granted port keep ownership for up to MAX_BURST grants.
module zbt_req_arbiter
  import zbt_req_arbiter_pkg::*;
#(
  parameter int ADDR_BITS    = ZBT_ADDR_BITS,
  parameter int READ_LATENCY = ZBT_READ_LATENCY,
  parameter int MAX_BURST    = 4
) (
  input  logic                  fpga_clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_rw_n,
  input  logic [ADDR_BITS-1:0]  a_addr,
  input  logic [`DATA_BITS-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rd_valid,
  input  logic                  b_req,
  input  logic                  b_rw_n,
  input  logic [ADDR_BITS-1:0]  b_addr,
  input  logic [`DATA_BITS-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rd_valid,
  output logic [`DATA_BITS-1:0] rd_data,
  output logic                  ui_valid,
  output logic                  ui_rw_n,
  output logic [ADDR_BITS-1:0]  ui_addr,
  output logic [`DATA_BITS-1:0] ui_write_data,
  input  logic [`DATA_BITS-1:0] ui_read_data
);

  if (MAX_BURST < 1 || READ_LATENCY < 1) begin : g_bad_cfg
    $error("zbt_req_arbiter: MAX_BURST and READ_LATENCY must be >= 1");
  end

  logic                  r_prio;
  logic                  w_gnt_vld;
  logic                  w_gnt_port;
  logic                  w_gnt_rw_n;
  logic [ADDR_BITS-1:0]  w_gnt_addr;
  logic [`DATA_BITS-1:0] w_gnt_wdata;
  rd_tag_t               w_tag_in;
  rd_tag_t               w_tag_out;

`ifdef ZBT_ARB_BURST_EN
  localparam int               CNT_W   = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

  logic             r_gnt_d;
  logic [CNT_W-1:0] r_burst_cnt;
  logic             w_hold;

  // The last-granted port is always the one r_prio points away from.
  assign w_hold = r_gnt_d && (r_prio ? a_req : b_req) && (r_burst_cnt != CNT_MAX);
`endif

  always_comb begin
    w_gnt_vld  = a_req | b_req;
    w_gnt_port = PORT_A;
    if (a_req && b_req) w_gnt_port = r_prio;
    else if (b_req)     w_gnt_port = PORT_B;
`ifdef ZBT_ARB_BURST_EN
    if (w_hold) w_gnt_port = ~r_prio;
`endif
    w_gnt_rw_n  = (w_gnt_port == PORT_B) ? b_rw_n  : a_rw_n;
    w_gnt_addr  = (w_gnt_port == PORT_B) ? b_addr  : a_addr;
    w_gnt_wdata = (w_gnt_port == PORT_B) ? b_wdata : a_wdata;
  end

  assign a_gnt = w_gnt_vld && (w_gnt_port == PORT_A);
  assign b_gnt = w_gnt_vld && (w_gnt_port == PORT_B);

  always_ff @(posedge fpga_clk) begin
    if (reset) begin
      r_prio        <= PORT_A;
      ui_valid      <= 1'b0;
      ui_rw_n       <= 1'b1;
      ui_addr       <= '0;
      ui_write_data <= '0;
    end else begin
      ui_valid <= w_gnt_vld;
      ui_rw_n  <= ~w_gnt_vld | w_gnt_rw_n;
      if (w_gnt_vld) begin
        r_prio        <= ~w_gnt_port;
        ui_addr       <= w_gnt_addr;
        ui_write_data <= w_gnt_wdata;
      end
    end
  end

`ifdef ZBT_ARB_BURST_EN
  // Count consecutive grants to the same port; saturate so a waiting port wins at once.
  always_ff @(posedge fpga_clk) begin
    if (reset) begin
      r_gnt_d     <= 1'b0;
      r_burst_cnt <= '0;
    end else begin
      r_gnt_d <= w_gnt_vld;
      if (w_gnt_vld) begin
        if (r_gnt_d && (w_gnt_port == ~r_prio)) begin
          if (r_burst_cnt != CNT_MAX) r_burst_cnt <= r_burst_cnt + 1'b1;
        end else begin
          r_burst_cnt <= '0;
        end
      end
    end
  end
`endif

  assign w_tag_in.vld  = w_gnt_vld & w_gnt_rw_n;
  assign w_tag_in.port = w_gnt_port;

  zbt_read_tag_pipe #(
    .DEPTH(READ_LATENCY + 1)
  ) u_tag_pipe (
    .fpga_clk(fpga_clk),
    .reset   (reset),
    .i_tag   (w_tag_in),
    .o_tag   (w_tag_out)
  );

  always_ff @(posedge fpga_clk) begin
    if (reset) begin
      rd_data    <= '0;
      a_rd_valid <= 1'b0;
      b_rd_valid <= 1'b0;
    end else begin
      a_rd_valid <= w_tag_out.vld && (w_tag_out.port == PORT_A);
      b_rd_valid <= w_tag_out.vld && (w_tag_out.port == PORT_B);
      if (w_tag_out.vld) rd_data <= ui_read_data;
    end
  end

endmodule

// File: tb/tb_zbt_req_arbiter.sv
// Directed-vector bench for zbt_req_arbiter with a simple latency-accurate SRAM model.
module tb_zbt_req_arbiter;

  localparam int AW = 19;
  localparam int DW = 36;
  localparam int RL = 5;

  logic          fpga_clk = 1'b0;
  logic          reset = 1'b1;
  logic          a_req = 1'b0, b_req = 1'b0, a_rw_n = 1'b1, b_rw_n = 1'b1;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_gnt, b_gnt, a_rd_valid, b_rd_valid;
  logic [DW-1:0] rd_data, ui_write_data, ui_read_data;
  logic          ui_valid, ui_rw_n;
  logic [AW-1:0] ui_addr;

  zbt_req_arbiter #(.ADDR_BITS(AW), .READ_LATENCY(RL), .MAX_BURST(4)) dut (
    .fpga_clk(fpga_clk), .reset(reset),
    .a_req(a_req), .a_rw_n(a_rw_n), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rd_valid(a_rd_valid),
    .b_req(b_req), .b_rw_n(b_rw_n), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rd_valid(b_rd_valid),
    .rd_data(rd_data), .ui_valid(ui_valid), .ui_rw_n(ui_rw_n), .ui_addr(ui_addr),
    .ui_write_data(ui_write_data), .ui_read_data(ui_read_data)
  );

  always #5 fpga_clk = ~fpga_clk;

  int cyc = 0;
  always @(posedge fpga_clk) cyc <= cyc + 1;

  // SRAM model: unwritten word i reads as C_0000_0000 | i; data returns RL cycles after ui command.
  logic [DW-1:0] mem   [256];
  logic [DW-1:0] dpipe [RL];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 36'hC_0000_0000 | DW'(i);
    for (int i = 0; i < RL; i++) dpipe[i] = '0;
  end
  always @(posedge fpga_clk) begin
    if (ui_valid && !ui_rw_n) mem[ui_addr[7:0]] = ui_write_data;
    for (int i = RL - 1; i > 0; i--) dpipe[i] <= dpipe[i-1];
    dpipe[0] <= (ui_valid && ui_rw_n) ? mem[ui_addr[7:0]] : '0;
  end
  assign ui_read_data = dpipe[RL-1];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Expected per-cycle observations, filled by the driver from table expectations.
  bit            exp_ui_chk [1024];
  bit            exp_ui_vld [1024];
  bit            exp_ui_rwn [1024];
  logic [AW-1:0] exp_ui_adr [1024];
  logic [DW-1:0] exp_ui_wd  [1024];
  bit            exp_arv    [1024];
  bit            exp_brv    [1024];
  logic [DW-1:0] exp_rd     [1024];
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_wd   = '0;
  bit            mon_en    = 1'b0;

  always @(negedge fpga_clk) begin
    if (mon_en) begin
      chk("a_rd_valid", 64'(a_rd_valid), 64'(exp_arv[cyc]));
      chk("b_rd_valid", 64'(b_rd_valid), 64'(exp_brv[cyc]));
      if (exp_arv[cyc] || exp_brv[cyc]) chk("rd_data", 64'(rd_data), 64'(exp_rd[cyc]));
      if (exp_ui_chk[cyc]) begin
        chk("ui_valid",      64'(ui_valid),      64'(exp_ui_vld[cyc]));
        chk("ui_rw_n",       64'(ui_rw_n),       64'(exp_ui_rwn[cyc]));
        chk("ui_addr",       64'(ui_addr),       64'(exp_ui_adr[cyc]));
        chk("ui_write_data", 64'(ui_write_data), 64'(exp_ui_wd[cyc]));
      end
    end
  end

  typedef struct {
    logic          a_req, b_req, a_rw_n, b_rw_n;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wd, b_wd;
    logic          exp_a_gnt, exp_b_gnt;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  function automatic vec_t mk(logic ar, logic br, logic arw, logic brw,
                              logic [AW-1:0] aa, logic [AW-1:0] ba,
                              logic [DW-1:0] aw, logic [DW-1:0] bw,
                              logic ea, logic eb, logic [DW-1:0] rd);
    vec_t v;
    v.a_req = ar; v.b_req = br; v.a_rw_n = arw; v.b_rw_n = brw;
    v.a_addr = aa; v.b_addr = ba; v.a_wd = aw; v.b_wd = bw;
    v.exp_a_gnt = ea; v.exp_b_gnt = eb; v.exp_rdata = rd;
    return v;
  endfunction

  task automatic apply(input vec_t v, input bit expect_ret);
    int c;
    logic p, rw;
    @(posedge fpga_clk); #1;
    a_req = v.a_req; b_req = v.b_req; a_rw_n = v.a_rw_n; b_rw_n = v.b_rw_n;
    a_addr = v.a_addr; b_addr = v.b_addr; a_wdata = v.a_wd; b_wdata = v.b_wd;
    #1;
    chk("a_gnt", 64'(a_gnt), 64'(v.exp_a_gnt));
    chk("b_gnt", 64'(b_gnt), 64'(v.exp_b_gnt));
    c = cyc;
    if (v.exp_a_gnt || v.exp_b_gnt) begin
      p  = v.exp_b_gnt;
      rw = p ? v.b_rw_n : v.a_rw_n;
      last_addr = p ? v.b_addr : v.a_addr;
      last_wd   = p ? v.b_wd   : v.a_wd;
      exp_ui_vld[c+1] = 1'b1;
      exp_ui_rwn[c+1] = rw;
      if (rw && expect_ret) begin
        if (p) exp_brv[c+RL+2] = 1'b1;
        else   exp_arv[c+RL+2] = 1'b1;
        exp_rd[c+RL+2] = v.exp_rdata;
      end
    end else begin
      exp_ui_vld[c+1] = 1'b0;
      exp_ui_rwn[c+1] = 1'b1;
    end
    exp_ui_adr[c+1] = last_addr;
    exp_ui_wd[c+1]  = last_wd;
    exp_ui_chk[c+1] = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  vec_t vecs[$];
  vec_t idle;

  initial begin
    idle = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);

    // Single port: write then read the same word back-to-back.
    vecs.push_back(mk(1, 0, 0, 1, 'h10, 0, 36'h5_A5A5_A5A5, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 'h10, 0, 0, 0, 1, 0, 36'h5_A5A5_A5A5));
    // Idle gap.
    for (int i = 0; i < 3; i++) vecs.push_back(idle);
`ifndef ZBT_ARB_BURST_EN
    // Priority pointer: B alone, then both -> A.
    vecs.push_back(mk(0, 1, 1, 1, 0, 'h21, 0, 0, 0, 1, 36'hC_0000_0021));
    vecs.push_back(mk(1, 1, 1, 1, 'h30, 'h31, 0, 0, 1, 0, 36'hC_0000_0030));
    vecs.push_back(mk(0, 1, 1, 0, 0, 'h40, 0, 36'h1_2345_6789, 0, 1, 0));
    // Contention: both hold req, ungranted side keeps its command.
    vecs.push_back(mk(1, 1, 1, 1, 'h50, 'h60, 0, 0, 1, 0, 36'hC_0000_0050));
    vecs.push_back(mk(1, 1, 1, 1, 'h51, 'h60, 0, 0, 0, 1, 36'hC_0000_0060));
    vecs.push_back(mk(1, 1, 1, 1, 'h51, 'h61, 0, 0, 1, 0, 36'hC_0000_0051));
    vecs.push_back(mk(1, 1, 1, 1, 'h52, 'h61, 0, 0, 0, 1, 36'hC_0000_0061));
    vecs.push_back(mk(1, 1, 1, 1, 'h52, 'h62, 0, 0, 1, 0, 36'hC_0000_0052));
    vecs.push_back(mk(1, 1, 1, 1, 'h53, 'h62, 0, 0, 0, 1, 36'hC_0000_0062));
    vecs.push_back(mk(1, 1, 1, 1, 'h53, 'h63, 0, 0, 1, 0, 36'hC_0000_0053));
    vecs.push_back(mk(1, 1, 1, 1, 'h54, 'h63, 0, 0, 0, 1, 36'hC_0000_0063));
    vecs.push_back(mk(0, 1, 1, 1, 0, 'h40, 0, 0, 0, 1, 36'h1_2345_6789));
    vecs.push_back(mk(1, 0, 0, 1, 'h44, 0, 36'hA_BCDE_F012, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 'h44, 0, 0, 0, 1, 0, 36'hA_BCDE_F012));
`else
    // Burst: A starts alone, then both hold -> A,A,A,A,B,B,B,B,A.
    vecs.push_back(mk(1, 0, 1, 1, 'h70, 0, 0, 0, 1, 0, 36'hC_0000_0070));
    vecs.push_back(mk(1, 1, 1, 1, 'h71, 'h80, 0, 0, 1, 0, 36'hC_0000_0071));
    vecs.push_back(mk(1, 1, 1, 1, 'h72, 'h80, 0, 0, 1, 0, 36'hC_0000_0072));
    vecs.push_back(mk(1, 1, 1, 1, 'h73, 'h80, 0, 0, 1, 0, 36'hC_0000_0073));
    vecs.push_back(mk(1, 1, 1, 1, 'h74, 'h80, 0, 0, 0, 1, 36'hC_0000_0080));
    vecs.push_back(mk(1, 1, 1, 1, 'h74, 'h81, 0, 0, 0, 1, 36'hC_0000_0081));
    vecs.push_back(mk(1, 1, 1, 1, 'h74, 'h82, 0, 0, 0, 1, 36'hC_0000_0082));
    vecs.push_back(mk(1, 1, 1, 1, 'h74, 'h83, 0, 0, 0, 1, 36'hC_0000_0083));
    vecs.push_back(mk(1, 0, 1, 1, 'h74, 0, 0, 0, 1, 0, 36'hC_0000_0074));
`endif
    for (int i = 0; i < RL + 4; i++) vecs.push_back(idle);

    // Power-on reset, then check reset values in the first free cycle.
    repeat (3) @(posedge fpga_clk);
    #1 reset = 1'b0;
    #2;
    chk("rst_ui_valid",      64'(ui_valid),      64'd0);
    chk("rst_ui_rw_n",       64'(ui_rw_n),       64'd1);
    chk("rst_ui_addr",       64'(ui_addr),       64'd0);
    chk("rst_ui_write_data", 64'(ui_write_data), 64'd0);
    chk("rst_rd_data",       64'(rd_data),       64'd0);
    chk("rst_a_rd_valid",    64'(a_rd_valid),    64'd0);
    chk("rst_b_rd_valid",    64'(b_rd_valid),    64'd0);
    chk("rst_a_gnt",         64'(a_gnt),         64'd0);
    chk("rst_b_gnt",         64'(b_gnt),         64'd0);
    mon_en = 1'b1;

    foreach (vecs[i]) apply(vecs[i], 1'b1);

    // Mid-stream reset: in-flight A read must never strobe.
    apply(mk(1, 0, 1, 1, 'h10, 0, 36'hF_FFFF_0000, 0, 1, 0, 0), 1'b0);
    apply(idle, 1'b1);
    @(posedge fpga_clk); #1 reset = 1'b1;
    @(posedge fpga_clk); #1 reset = 1'b0;
    #2;
    chk("mid_rst_ui_valid",      64'(ui_valid),      64'd0);
    chk("mid_rst_ui_rw_n",       64'(ui_rw_n),       64'd1);
    chk("mid_rst_ui_addr",       64'(ui_addr),       64'd0);
    chk("mid_rst_ui_write_data", 64'(ui_write_data), 64'd0);
    chk("mid_rst_rd_data",       64'(rd_data),       64'd0);
    last_addr = '0;
    last_wd   = '0;
    for (int i = 0; i < RL + 6; i++) apply(idle, 1'b1);

    @(posedge fpga_clk); #2;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
